// File: rtl/mux_serial_feeder_if.sv
// ---------------------------------------------------------------------------
// mux_serial_feeder_if
// Upstream word handshake plus the multiplexor drive lines of the
// serial feeder.
//   master : the upstream producer / observer of the mux drive lines.
//   slave  : the feeder itself.
// ---------------------------------------------------------------------------
interface mux_serial_feeder_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [2:0]        in_chan;
   logic [2:0]        sel;
   logic              sig;
   logic              busy;
   logic              frame_done;

   modport master (
      output in_valid, in_data, in_chan,
      input  in_ready, sel, sig, busy, frame_done
   );

   modport slave (
      input  in_valid, in_data, in_chan,
      output in_ready, sel, sig, busy, frame_done
   );
endinterface

// File: rtl/mux_serial_feeder.sv
// ---------------------------------------------------------------------------
// mux_serial_feeder
// Upstream stage of the 1-to-8 multiplexor. A word accepted over the
// valid/ready handshake is shifted out MSB-first on sig, one bit per clock,
// while sel holds the destination channel. A programmable low gap follows
// each frame before the next word is accepted. All outputs are registered.
//
// Optional feature (macro MUX_SERIAL_FEEDER_PARITY_EN): append one
// even-parity bit after bit 0; frame_done then marks the parity cycle.
//
// The interface instance must carry the same DATA_W as this module.
// ---------------------------------------------------------------------------
module mux_serial_feeder #(
   parameter int DATA_W     = 8,   // 2..32
   parameter int GAP_CYCLES = 1    // 0..15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux_serial_feeder_if.slave   bus
);

`ifdef MUX_SERIAL_FEEDER_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   // Bits shifted out per frame (data plus optional parity).
   localparam int FRAME_W = DATA_W + PAR_W;
   localparam int CNT_W   = $clog2(FRAME_W);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   // Reject illegal configurations at elaboration.
   if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
      $error("mux_serial_feeder: DATA_W must be 2..32");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
      $error("mux_serial_feeder: GAP_CYCLES must be 0..15");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Registered state and outputs.
   state_t             r_state;
   logic [FRAME_W-1:0] r_shift;     // bits still to be sent, MSB next
   logic [CNT_W-1:0]   r_cnt;       // bits remaining after the one on sig
   logic [3:0]         r_gap_cnt;   // gap cycles remaining after this one
   logic [2:0]         r_sel;
   logic               r_sig;
   logic               r_in_ready;
   logic               r_busy;
   logic               r_frame_done;

   // Next-state values.
   state_t             w_state_nxt;
   logic [FRAME_W-1:0] w_shift_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [3:0]         w_gap_nxt;
   logic [2:0]         w_sel_nxt;
   logic               w_sig_nxt;
   logic               w_ready_nxt;
   logic               w_busy_nxt;
   logic               w_fd_nxt;

   logic               w_accept;
   logic [FRAME_W-1:0] w_frame;

   assign w_accept = bus.in_valid && r_in_ready;

   // Frame image as it will leave on sig: the word, then parity if enabled.
`ifdef MUX_SERIAL_FEEDER_PARITY_EN
   assign w_frame = {bus.in_data, ^bus.in_data};
`else
   assign w_frame = bus.in_data;
`endif

   // Next-state and next-output decode for the IDLE/SHIFT/GAP sequencer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned; that is what keeps this block from inferring latches.
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_sel_nxt   = r_sel;
      w_sig_nxt   = 1'b0;
      w_ready_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
      w_fd_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            if (w_accept) begin
               // First bit goes straight onto sig; the rest wait in r_shift.
               w_state_nxt = ST_SHIFT;
               w_sig_nxt   = w_frame[FRAME_W-1];
               w_shift_nxt = w_frame << 1;
               w_cnt_nxt   = CNT_LOAD;
               w_sel_nxt   = bus.in_chan;
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (r_cnt != CNT_ZERO) begin
               w_sig_nxt   = r_shift[FRAME_W-1];
               w_shift_nxt = r_shift << 1;
               w_cnt_nxt   = r_cnt - CNT_ONE;
               // The bit loaded now is the last one of the frame.
               w_fd_nxt    = (r_cnt == CNT_ONE);
            end else if (GAP_CYCLES > 0) begin
               w_state_nxt = ST_GAP;
               w_gap_nxt   = GAP_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
               w_ready_nxt = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end

         ST_GAP: begin
            if (r_gap_cnt == 4'd0) begin
               w_state_nxt = ST_IDLE;
               w_ready_nxt = 1'b1;
               w_busy_nxt  = 1'b0;
            end else begin
               w_gap_nxt = r_gap_cnt - 4'd1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any frame immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the shift register and counters are reset too, so an aborted
      // frame leaves no stale bits behind; nothing here is a RAM.
      if (!rst_n) begin
         r_shift      <= '0;
         r_cnt        <= '0;
         r_gap_cnt    <= '0;
         r_sel        <= 3'd0;
         r_sig        <= 1'b0;
         r_in_ready   <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_shift      <= w_shift_nxt;
         r_cnt        <= w_cnt_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_sel        <= w_sel_nxt;
         r_sig        <= w_sig_nxt;
         r_in_ready   <= w_ready_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_fd_nxt;
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.sel        = r_sel;
   assign bus.sig        = r_sig;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_serial_feeder.sv
// ---------------------------------------------------------------------------
// tb_mux_serial_feeder
// Two feeders (GAP_CYCLES=1 and GAP_CYCLES=0) share clock and reset.
// A vector table drives whole frames; hand sequences cover the held-valid
// handshake and the asynchronous mid-frame reset. Build with
// MUX_SERIAL_FEEDER_PARITY_EN to exercise the parity bit.
// ---------------------------------------------------------------------------
module tb_mux_serial_feeder;
   localparam int DATA_W = 8;
`ifdef MUX_SERIAL_FEEDER_PARITY_EN
   localparam int FW = DATA_W + 1;
`else
   localparam int FW = DATA_W;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_serial_feeder_if #(.DATA_W(DATA_W)) bus1 ();
   mux_serial_feeder_if #(.DATA_W(DATA_W)) bus0 ();

   mux_serial_feeder #(.DATA_W(DATA_W), .GAP_CYCLES(1)) dut_gap1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   mux_serial_feeder #(.DATA_W(DATA_W), .GAP_CYCLES(0)) dut_gap0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));

   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       fd;
      logic       sig;
      logic [2:0] sel;
   } obs_t;

   // Stimulus plus hand-computed expected parity bit.
   typedef struct {
      logic [7:0] data;
      logic [2:0] chan;
      bit         g0;    // 1: use the zero-gap feeder
      bit         par;   // expected even-parity bit
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic obs_t get_obs(input bit g0);
      obs_t o;
      if (g0) o = '{bus0.in_ready, bus0.busy, bus0.frame_done, bus0.sig, bus0.sel};
      else    o = '{bus1.in_ready, bus1.busy, bus1.frame_done, bus1.sig, bus1.sel};
      return o;
   endfunction

   task automatic drive(input bit g0, input logic v, input logic [7:0] d, input logic [2:0] c);
      if (g0) begin
         bus0.in_valid = v; bus0.in_data = d; bus0.in_chan = c;
      end else begin
         bus1.in_valid = v; bus1.in_data = d; bus1.in_chan = c;
      end
   endtask

   // Advance to a negedge where in_ready is high, bounded.
   task automatic wait_ready(input bit g0, input string tag);
      obs_t o;
      o = get_obs(g0);
      for (int k = 0; k < 64 && !o.ready; k++) begin
         @(negedge clk);
         o = get_obs(g0);
      end
      if (!o.ready) check({tag, " ready_timeout"}, 0, 1);
   endtask

   // Send one word and check every cycle of the frame, the gap and IDLE.
   task automatic run_frame(input bit g0, input logic [7:0] data, input logic [2:0] chan,
                            input bit par, input string tag);
      logic [8:0] bits;
      obs_t       o;
      int         gap;
      gap  = g0 ? 0 : 1;
      bits = {data, par};
      wait_ready(g0, tag);
      drive(g0, 1'b1, data, chan);
      @(posedge clk);
      @(negedge clk);
      drive(g0, 1'b0, ~data, ~chan);   // must be ignored after accept
      for (int i = 0; i < FW; i++) begin
         o = get_obs(g0);
         check($sformatf("%s sig[%0d]", tag, i), o.sig, bits[8-i]);
         check($sformatf("%s sel[%0d]", tag, i), o.sel, chan);
         check($sformatf("%s fd[%0d]", tag, i), o.fd, (i == FW-1));
         check($sformatf("%s busy[%0d]", tag, i), o.busy, 1);
         check($sformatf("%s rdy[%0d]", tag, i), o.ready, 0);
         @(negedge clk);
      end
      for (int i = 0; i < gap; i++) begin
         o = get_obs(g0);
         check({tag, " gap sig"}, o.sig, 0);
         check({tag, " gap busy"}, o.busy, 1);
         check({tag, " gap rdy"}, o.ready, 0);
         check({tag, " gap fd"}, o.fd, 0);
         check({tag, " gap sel"}, o.sel, chan);
         @(negedge clk);
      end
      for (int i = 0; i < 2; i++) begin
         o = get_obs(g0);
         check({tag, " idle rdy"}, o.ready, 1);
         check({tag, " idle busy"}, o.busy, 0);
         check({tag, " idle sig"}, o.sig, 0);
         check({tag, " idle sel held"}, o.sel, chan);
         @(negedge clk);
      end
   endtask

   initial begin
      vec_t vecs[11];
      obs_t o;

      vecs[0]  = '{8'hA5, 3'd5, 1'b0, 1'b0};
      vecs[1]  = '{8'h81, 3'd0, 1'b1, 1'b0};
      vecs[2]  = '{8'h07, 3'd3, 1'b0, 1'b1};
      vecs[3]  = '{8'h00, 3'd0, 1'b0, 1'b0};
      vecs[4]  = '{8'h01, 3'd1, 1'b0, 1'b1};
      vecs[5]  = '{8'h02, 3'd2, 1'b0, 1'b1};
      vecs[6]  = '{8'h03, 3'd3, 1'b0, 1'b0};
      vecs[7]  = '{8'h04, 3'd4, 1'b0, 1'b1};
      vecs[8]  = '{8'h05, 3'd5, 1'b0, 1'b0};
      vecs[9]  = '{8'h06, 3'd6, 1'b0, 1'b0};
      vecs[10] = '{8'h07, 3'd7, 1'b0, 1'b1};

      drive(1'b0, 1'b0, 8'h00, 3'd0);
      drive(1'b1, 1'b0, 8'h00, 3'd0);

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      o = get_obs(1'b0);
      check("rst in_ready", o.ready, 1);
      check("rst sel", o.sel, 0);
      check("rst sig", o.sig, 0);
      check("rst busy", o.busy, 0);
      check("rst fd", o.fd, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven frames: basic, zero gap, parity and channel sweep.
      for (int v = 0; v < 11; v++) begin
         run_frame(vecs[v].g0, vecs[v].data, vecs[v].chan, vecs[v].par,
                   $sformatf("vec%0d", v));
      end

      // Held valid: later in_data/in_chan changes are ignored mid-frame and
      // the next word is taken on the first IDLE cycle.
      wait_ready(1'b0, "hold");
      drive(1'b0, 1'b1, 8'hFF, 3'd2);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b1, 8'h00, 3'd7);
      for (int i = 0; i < FW; i++) begin
         o = get_obs(1'b0);
         check($sformatf("hold sig[%0d]", i), o.sig, (i < DATA_W) ? 1 : 0);
         check($sformatf("hold sel[%0d]", i), o.sel, 2);
         @(negedge clk);
      end
      o = get_obs(1'b0);
      check("hold gap sig", o.sig, 0);
      check("hold gap rdy", o.ready, 0);
      @(negedge clk);
      o = get_obs(1'b0);
      check("hold idle rdy", o.ready, 1);
      check("hold idle sel", o.sel, 2);
      @(negedge clk);
      o = get_obs(1'b0);
      check("hold 2nd sel", o.sel, 7);
      check("hold 2nd busy", o.busy, 1);
      check("hold 2nd rdy", o.ready, 0);
      check("hold 2nd sig", o.sig, 0);
      drive(1'b0, 1'b0, 8'h00, 3'd0);
      wait_ready(1'b0, "hold end");
      o = get_obs(1'b0);
      check("hold end sel", o.sel, 7);

      // Asynchronous reset on the 4th bit of 8'hC3 to channel 6.
      wait_ready(1'b0, "rst_mid");
      drive(1'b0, 1'b1, 8'hC3, 3'd6);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 3'd0);
      for (int i = 0; i < 3; i++) @(negedge clk);
      o = get_obs(1'b0);
      check("rst_mid bit4 sig", o.sig, 0);
      check("rst_mid sel", o.sel, 6);
      check("rst_mid busy", o.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      o = get_obs(1'b0);
      check("rst_async sel", o.sel, 0);
      check("rst_async sig", o.sig, 0);
      check("rst_async busy", o.busy, 0);
      check("rst_async rdy", o.ready, 1);
      check("rst_async fd", o.fd, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         o = get_obs(1'b0);
         check("rst_hold fd", o.fd, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < DATA_W; i++) begin
         o = get_obs(1'b0);
         check("post_rst no fd", o.fd, 0);
         check("post_rst idle", o.busy, 0);
         @(negedge clk);
      end
      run_frame(1'b0, 8'h01, 3'd1, 1'b1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/mux_serial_feeder.md
Name: mux_serial_feeder

Overview:
- Upstream stage of the 1-to-8 multiplexor.
- Accepts a parallel data word and a 3-bit destination channel over a valid/ready handshake.
- Drives the multiplexor's 3-bit select and single-bit input signal, so the word appears MSB-first on the selected output line, one bit per clock.
- Holds select stable for the whole frame and inserts a programmable low gap between frames.

Parameters:
- DATA_W, 8, data word width in bits; legal range 2..32.
- GAP_CYCLES, 1, number of idle-low cycles after each frame before the next word is accepted; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream word is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  word to serialize.
- in_chan  input  3  destination channel, 0..7.
- sel  output  3  drives multiplexor select Y.
- sig  output  1  drives multiplexor InpSignal.
- busy  output  1  high while a frame or gap is in progress.
- frame_done  output  1  one-cycle pulse marking the last bit of a frame.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - State IDLE.
  - in_ready=1, sel=0, sig=0, busy=0, frame_done=0.
  - Shift register and counters cleared.
- FSM states: IDLE, SHIFT, GAP. All outputs are registered.
- IDLE:
  - in_ready=1, busy=0, sig=0, sel holds the last used channel (0 after reset).
  - Accept occurs when in_valid&in_ready at a rising edge.
  - On accept: latch in_data into the shift register, latch in_chan into sel, load the bit counter with DATA_W-1, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - sig = current MSB of the shift register.
  - First data bit appears on sig the cycle after the accept edge, so latency is 1 cycle.
  - Shift left by one and decrement the counter each cycle.
  - On the cycle sig carries bit 0: frame_done=1.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - sig=0, sel held, in_ready=0, busy=1.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
- Frame length: DATA_W cycles of data, plus GAP_CYCLES gap cycles.
- Minimum accept-to-accept spacing is DATA_W+GAP_CYCLES+1 cycles, because in_ready is reasserted only in IDLE. No back-to-back accept.
- in_data and in_chan are sampled only at the accept edge. Changes during SHIFT/GAP have no effect.
- in_valid held high in IDLE: accepted on the first IDLE cycle.
- sel never changes except at an accept edge or reset, so the multiplexor output never glitches mid-frame.
- rst_n asserted mid-frame: frame aborted immediately (asynchronous). Outputs take their reset values, no frame_done pulse. After release the block is in IDLE.
- in_chan is a 3-bit value, so all encodings are legal with no range check.

Optional Feature:
- Macro: MUX_SERIAL_FEEDER_PARITY_EN.
- When defined:
  - One even-parity bit (XOR of the latched word) is appended on sig after bit 0, in an extra SHIFT cycle.
  - frame_done moves to the parity cycle; it does not pulse on bit 0.
  - Frame length is DATA_W+1.
- When undefined: no parity bit, and behaviour is exactly as above.

Test Plan:
- Basic frame (DATA_W=8, GAP_CYCLES=1, parity off): reset, then accept in_data=8'hA5, in_chan=5.
  - sel=5 from the cycle after accept.
  - sig sequence 1,0,1,0,0,1,0,1 on cycles 1..8.
  - frame_done only on cycle 8.
  - sig=0 on cycle 9; in_ready=1 on cycle 10.
- Handshake and stability: in_valid held high with 8'hFF/chan 2, then in_data changed to 8'h00 and in_chan to 7 during SHIFT.
  - Sig stays all ones and sel stays 2 for 8 cycles.
  - Second word (8'h00, chan 7) is accepted on the first IDLE cycle.
- Zero gap (GAP_CYCLES=0): send 8'h81 to chan 0.
  - in_ready=1 on the cycle after frame_done.
  - sig pattern 1,0,0,0,0,0,0,1.
- Reset mid-frame: assert rst_n=0 on the 4th bit of 8'hC3 to chan 6.
  - sel=0, sig=0, busy=0, in_ready=1 immediately, without waiting for a clock edge.
  - No frame_done pulse.
  - After release, a new word 8'h01 to chan 1 serializes correctly.
- Parity (MUX_SERIAL_FEEDER_PARITY_EN defined):
  - 8'hA5 gives 9 bits: data, then parity 0; frame_done on cycle 9.
  - 8'h07 gives parity bit 1.
- Channel sweep: 8 frames with chan 0..7, data = chan value.
  - sel matches each channel for its full frame duration.
  - sel holds the previous value through IDLE.
